// File: rtl/fetch_stage.sv
// OTTER RV32I fetch stage: PC, synchronous imem requests and a
// 2-entry {pc, instr} queue presented to decode with redirect flush.
// Ports: IF_CLK/IF_RST_N; IMEM_RD_EN/IMEM_ADDR/IMEM_DOUT;
// BR_TAKEN/BR_TARGET; DE_READY; IF_VALID/IR/PC_COUNT/PC_PLUS4.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        IF_CLK,
  input  logic        IF_RST_N,
  output logic        IMEM_RD_EN,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DOUT,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  input  logic        DE_READY,
  output logic        IF_VALID,
  output logic [31:0] IR,
  output logic [31:0] PC_COUNT,
  output logic [31:0] PC_PLUS4
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  logic [31:0] pc_q, pc_d;
  ent_t        q0_q, q0_d;
  ent_t        q1_q, q1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        infl_q, infl_d;
  logic [31:0] ipc_q, ipc_d;

  logic        pop;
  logic        resp;
  logic        issue;
  logic [2:0]  occ;
  logic [31:0] tgt;
  ent_t        new_e;
  logic        unused_br_lo;

  assign unused_br_lo = ^BR_TARGET[1:0];
  assign tgt = {BR_TARGET[31:2], 2'b00};

  assign IF_VALID = (cnt_q != 2'd0);
  assign pop  = IF_VALID & DE_READY & ~BR_TAKEN;
  // A response arriving in a redirect cycle belongs
  // to the wrong path and is dropped.
  assign resp = infl_q & ~BR_TAKEN;

  // Slots already committed after this cycle's pop;
  // every in-flight request owns one queue slot.
  assign occ = {1'b0, cnt_q} + {2'b00, infl_q}
             - {2'b00, pop};

  // No requests while reset is held.
  assign issue = IF_RST_N & (BR_TAKEN | (occ < 3'd2));

  assign IMEM_RD_EN = issue;
  assign IMEM_ADDR  = BR_TAKEN ? tgt : pc_q;

  assign new_e.pc = ipc_q;
  assign new_e.ir = IMEM_DOUT;

  always_comb begin
    pc_d   = pc_q;
    ipc_d  = ipc_q;
    infl_d = issue;
    q0_d   = q0_q;
    q1_d   = q1_q;
    cnt_d  = cnt_q;
    if (issue) begin
      ipc_d = IMEM_ADDR;
      pc_d  = IMEM_ADDR + 32'd4;
    end
    unique case (1'b1)
      BR_TAKEN: begin
        cnt_d = 2'd0;
      end
      (pop & resp): begin
        if (cnt_q == 2'd2) begin
          q0_d = q1_q;
          q1_d = new_e;
        end else begin
          q0_d = new_e;
        end
      end
      (pop & ~resp): begin
        q0_d  = q1_q;
        cnt_d = cnt_q - 2'd1;
      end
      (~pop & resp): begin
        if (cnt_q == 2'd0) q0_d = new_e;
        else               q1_d = new_e;
        cnt_d = cnt_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge IF_CLK or negedge IF_RST_N) begin
    if (!IF_RST_N) begin
      pc_q   <= {RESET_PC[31:2], 2'b00};
      ipc_q  <= '0;
      infl_q <= 1'b0;
      q0_q   <= '0;
      q1_q   <= '0;
      cnt_q  <= 2'd0;
    end else begin
      pc_q   <= pc_d;
      ipc_q  <= ipc_d;
      infl_q <= infl_d;
      q0_q   <= q0_d;
      q1_q   <= q1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign IR       = IF_VALID ? q0_q.ir : NOP_INSTR;
  assign PC_COUNT = IF_VALID ? q0_q.pc : 32'd0;
  assign PC_PLUS4 = IF_VALID ? (q0_q.pc + 32'd4) : 32'd0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle table for fetch/stall/redirect,
// accepted-stream scoreboard, wrap instance and async reset.
module tb_fetch_stage;

  typedef struct {
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        erd;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] epc;
  } vec_t;

  logic clk;
  logic rst_n;

  logic        rd_en, br, rdy, valid;
  logic [31:0] addr, dout, tgt, ir, pcc, pc4;

  logic        w_rd_en, w_br, w_rdy, w_valid;
  logic [31:0] w_addr, w_dout, w_tgt, w_ir, w_pcc, w_pc4;

  int errors = 0;
  int checks = 0;
  int accepted = 0;
  logic [31:0] sb[$];
  vec_t tbl[20];

  fetch_stage u_dut (
    .IF_CLK(clk), .IF_RST_N(rst_n),
    .IMEM_RD_EN(rd_en), .IMEM_ADDR(addr),
    .IMEM_DOUT(dout),
    .BR_TAKEN(br), .BR_TARGET(tgt),
    .DE_READY(rdy), .IF_VALID(valid),
    .IR(ir), .PC_COUNT(pcc), .PC_PLUS4(pc4)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .IF_CLK(clk), .IF_RST_N(rst_n),
    .IMEM_RD_EN(w_rd_en), .IMEM_ADDR(w_addr),
    .IMEM_DOUT(w_dout),
    .BR_TAKEN(w_br), .BR_TARGET(w_tgt),
    .DE_READY(w_rdy), .IF_VALID(w_valid),
    .IR(w_ir), .PC_COUNT(w_pcc), .PC_PLUS4(w_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: word at addr N = 0x1000_0000+N.
  always @(posedge clk) begin
    if (rd_en)   dout   <= 32'h1000_0000 + addr;
    if (w_rd_en) w_dout <= 32'h1000_0000 + w_addr;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] base);
    sb.delete();
    for (int k = 0; k < 16; k++) sb.push_back(base + 32'(4 * k));
  endtask

  function automatic vec_t mk(logic r, logic b, logic [31:0] t,
                              logic erd, logic [31:0] ea,
                              logic ev, logic [31:0] ep);
    vec_t v;
    v.rdy = r; v.br = b; v.tgt = t;
    v.erd = erd; v.eaddr = ea; v.ev = ev; v.epc = ep;
    return v;
  endfunction

  // Accepted-instruction scoreboard, evaluated at the sample point.
  task automatic score();
    logic [31:0] e;
    if (valid && rdy && !br) begin
      accepted++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got pc %h want none", pcc);
      end else begin
        e = sb.pop_front();
        check("sb_pc", pcc, e);
        check("sb_ir", ir, 32'h1000_0000 + e);
        check("sb_pc4", pc4, e + 32'd4);
      end
    end
  endtask

  task automatic run_row(input int i, input logic first);
    vec_t v;
    v = tbl[i];
    rdy = v.rdy;
    br  = v.br;
    tgt = v.tgt;
    if (v.br) push_stream({v.tgt[31:2], 2'b00});
    @(negedge clk);
    check($sformatf("rd_en[%0d]", i), 32'(rd_en), 32'(v.erd));
    if (v.erd) check($sformatf("addr[%0d]", i), addr, v.eaddr);
    check($sformatf("valid[%0d]", i), 32'(valid), 32'(v.ev));
    check($sformatf("pc[%0d]", i), pcc, v.ev ? v.epc : 32'd0);
    check($sformatf("ir[%0d]", i), ir,
          v.ev ? 32'h1000_0000 + v.epc : 32'h0000_0013);
    check($sformatf("pc4[%0d]", i), pc4,
          v.ev ? v.epc + 32'd4 : 32'd0);
    score();
    if (first && i == 0) check("w_addr0", w_addr, 32'hFFFF_FFFC);
    if (first && i == 2) begin
      check("w_pc_c2", w_pcc, 32'hFFFF_FFFC);
      check("w_pc4_c2", w_pc4, 32'h0000_0000);
    end
    if (first && i == 3) begin
      check("w_pc_c3", w_pcc, 32'h0000_0000);
      check("w_pc4_c3", w_pc4, 32'h0000_0004);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0,         1, 32'h000, 0, 0);
    tbl[1]  = mk(1, 0, 0,         1, 32'h004, 0, 0);
    tbl[2]  = mk(1, 0, 0,         1, 32'h008, 1, 32'h000);
    tbl[3]  = mk(1, 0, 0,         1, 32'h00C, 1, 32'h004);
    tbl[4]  = mk(0, 0, 0,         0, 32'h000, 1, 32'h008);
    tbl[5]  = mk(0, 0, 0,         0, 32'h000, 1, 32'h008);
    tbl[6]  = mk(0, 0, 0,         0, 32'h000, 1, 32'h008);
    tbl[7]  = mk(0, 0, 0,         0, 32'h000, 1, 32'h008);
    tbl[8]  = mk(0, 0, 0,         0, 32'h000, 1, 32'h008);
    tbl[9]  = mk(1, 0, 0,         1, 32'h010, 1, 32'h008);
    tbl[10] = mk(1, 0, 0,         1, 32'h014, 1, 32'h00C);
    tbl[11] = mk(1, 1, 32'h103,   1, 32'h100, 1, 32'h010);
    tbl[12] = mk(1, 0, 0,         1, 32'h104, 0, 0);
    tbl[13] = mk(1, 0, 0,         1, 32'h108, 1, 32'h100);
    tbl[14] = mk(0, 0, 0,         0, 32'h000, 1, 32'h104);
    tbl[15] = mk(0, 0, 0,         0, 32'h000, 1, 32'h104);
    tbl[16] = mk(0, 1, 32'h200,   1, 32'h200, 1, 32'h104);
    tbl[17] = mk(0, 0, 0,         1, 32'h204, 0, 0);
    tbl[18] = mk(1, 0, 0,         1, 32'h208, 1, 32'h200);
    tbl[19] = mk(1, 0, 0,         1, 32'h20C, 1, 32'h204);

    rst_n = 1'b0;
    rdy = 1'b1; br = 1'b0; tgt = '0;
    w_rdy = 1'b1; w_br = 1'b0; w_tgt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ir", ir, 32'h0000_0013);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    push_stream(32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) run_row(i, 1'b1);

    // Mid-stream async reset: one entry queued, 0x20C in flight.
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_ir", ir, 32'h0000_0013);
    check("arst_pc", pcc, 32'd0);
    check("arst_pc4", pc4, 32'd0);
    check("arst_rd_en", 32'(rd_en), 32'd0);
    push_stream(32'h0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_row(i, 1'b0);

    check("accepted", 32'(accepted), 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
